// File: rtl/aes_package.sv
// Shared AES datapath types and constants.
// Block/word geometry plus serializer control and status bundles.
package aes_package;

  localparam int AES_BLOCK_W       = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = AES_BLOCK_W / AES_WORD_W;
  localparam int AES_CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_ser_state_e;

  typedef struct packed {
    logic                 start;
    logic                 clear;
    logic [AES_CNT_W-1:0] nb_blocks;
  } ctrl_serializer_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [AES_CNT_W-1:0] blk_cnt;
  } flags_serializer_t;

endpackage

// File: rtl/aes_blk_fifo2.sv
// Two-entry block FIFO holding whole AES blocks.
// Head is always the oldest block; push and pop may coincide.
module aes_blk_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         push_ok;
  logic         pop_ok;

  assign full_o  = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clear_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/aes_block_serializer.sv
// Serializes 128-bit AES blocks into 32-bit stream words, low word first.
// Block-count job control raises done_o once the last word is taken.
module aes_block_serializer
  import aes_package::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int WORD_W  = AES_WORD_W,
  parameter int CNT_W   = AES_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    nb_blocks_i,
  input  logic                blk_valid_i,
  output logic                blk_ready_o,
  input  logic [BLOCK_W-1:0]  blk_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WORD_W-1:0]   out_data_o,
  output logic [WORD_W/8-1:0] out_strb_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    blk_cnt_o
);

  localparam int NW    = BLOCK_W / WORD_W;
  localparam int IDX_W = $clog2(NW);

  aes_ser_state_e     state_q;
  logic [IDX_W-1:0]   w_q;
  logic [CNT_W-1:0]   nb_q;
  logic [CNT_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLOCK_W-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               hs;
  logic               pop;
  logic               last;
  logic               unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // Ready depends only on registered state, never on out_ready_i.
  assign blk_ready_o = (state_q == RUN) && !full && (acc_q < nb_q);
  assign push        = blk_valid_i & blk_ready_o;
  assign out_valid_o = ~empty;
  assign hs          = out_valid_o & out_ready_i;
  assign pop         = hs && (w_q == IDX_W'(NW - 1));
  assign last        = (cnt_q + CNT_W'(1)) == nb_q;
  assign out_data_o  = head[WORD_W*int'(w_q) +: WORD_W];
  assign out_strb_o  = '1;
  assign busy_o      = state_q == RUN;
  assign done_o      = state_q == DONE;
  assign blk_cnt_o   = cnt_q;

  aes_blk_fifo2 #(
    .W(BLOCK_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .push_i (push),
    .data_i (blk_data_i),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      w_q     <= '0;
      nb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      w_q     <= '0;
      nb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (hs)   w_q   <= w_q + IDX_W'(1);
      if (push) acc_q <= acc_q + CNT_W'(1);
      if (pop)  cnt_q <= cnt_q + CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            nb_q    <= nb_blocks_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            state_q <= (nb_blocks_i == '0) ? DONE : RUN;
          end
        end
        RUN:     if (pop && last) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
Transmit-side counterpart of the word-gathering AES engine input. It accepts whole 128-bit AES blocks from the cipher datapath and serializes each into four 32-bit HWPE-stream words, lowest word (bits [31:0]) first. A 2-entry block buffer sustains one word per cycle. A block-count job control produces a done pulse for the controller/FSM.

Parameters:
BLOCK_W, 128, block width in bits; fixed to the AES block size.
WORD_W, 32, stream word width in bits; BLOCK_W/WORD_W = 4 words per block.
CNT_W, 16, width of block counters and nb_blocks_i.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
test_mode_i  in  1  unused, reserved
clear_i  in  1  synchronous soft clear
start_i  in  1  job start, sampled only in IDLE
nb_blocks_i  in  CNT_W  number of blocks in the job
blk_valid_i  in  1  block-side valid
blk_ready_o  out  1  block-side ready
blk_data_i  in  BLOCK_W  block data
out_valid_o  out  1  stream valid (source to hwpe_stream_intf_stream)
out_ready_i  in  1  stream ready
out_data_o  out  WORD_W  stream data
out_strb_o  out  WORD_W/8  byte strobes, always all ones
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse at job end
blk_cnt_o  out  CNT_W  blocks fully emitted in the current job

Behaviour:
- Reset (rst_ni=0, async): state IDLE, buffer empty, word index 0, all counters 0. Every output is 0 except out_strb_o, which is all ones.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN on start_i; latch nb_blocks_i and clear the counters.
  - If the latched nb_blocks is 0: IDLE -> DONE directly.
  - RUN -> DONE on the output handshake of word 3 of block nb_blocks-1.
  - DONE -> IDLE unconditionally after 1 cycle; done_o=1 only in DONE.
- Block side:
  - blk_ready_o = (state==RUN) && (entries<2) && (accepted<nb_blocks).
  - blk_ready_o is a function of registered state only, with no combinational path from out_ready_i. When the buffer is full, a same-cycle pop does not enable a push.
  - Push when blk_valid_i && blk_ready_o.
- Output side:
  - out_valid_o = entries>0.
  - out_data_o = head[32*w+31 : 32*w], where w is the word index (0..3).
  - Handshake = out_valid_o && out_ready_i. On handshake, w increments. At w=3 the handshake wraps w to 0, pops the head and increments blk_cnt_o.
  - While out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold stable.
- Latency and throughput:
  - A block pushed at cycle t into an empty buffer appears as word 0 at t+1.
  - Sustained rate is 1 word/cycle, 4 cycles/block, with no bubbles when upstream keeps the buffer non-empty.
- Simultaneous push and pop (entries==1): the count stays 1 and the new block becomes head after the pop.
- Blocks offered beyond nb_blocks are not accepted (ready stays 0).
- start_i outside IDLE is ignored.
- clear_i (synchronous, highest priority after reset):
  - Forces IDLE, empties the buffer, zeroes w and the counters.
  - No done_o pulse; out_valid_o=0 the following cycle.
  - A word mid-stall is discarded.

Decomposition:
- Add to aes_package:
  - AES_BLOCK_W=128, AES_WORD_W=32, AES_WORDS_PER_BLK=4.
  - Typedef aes_ser_state_e {IDLE, RUN, DONE}.
  - Typedefs ctrl_serializer_t {start, clear, nb_blocks} and flags_serializer_t {busy, done, blk_cnt}, for grouping in the controller.
- One sub-module: aes_blk_fifo2, a 2-entry BLOCK_W-wide FIFO with push/pop/full/empty and head output. The serializer holds the FSM, word index and counters.

Test Plan:
1. nb_blocks=1, block 0x33333333_22222222_11111111_00000000, out_ready_i=1 -> words 0x00000000, 0x11111111, 0x22222222, 0x33333333 on 4 consecutive cycles starting 1 cycle after push; done_o pulses 1 cycle after the last word; blk_cnt_o=1.
2. nb_blocks=4, blocks continuously valid, out_ready_i=1 -> 16 words with no bubbles, blk_ready_o never high while 2 entries are held, done_o exactly once, blk_cnt_o=4.
3. Backpressure: out_ready_i=0 for 5 cycles while word 2 is valid -> out_data_o=word 2 stable all 5 cycles; the sequence resumes unchanged; buffer fills to 2 and blk_ready_o=0.
4. nb_blocks=0 with start_i -> DONE next cycle, done_o one pulse, no out_valid_o, blk_ready_o never 1.
5. clear_i asserted mid-block (after word 1, buffer full) -> next cycle out_valid_o=0, busy_o=0, blk_cnt_o=0, no done_o; a new start_i job with nb_blocks=1 behaves as scenario 1.
6. rst_ni pulsed low asynchronously mid-job -> all outputs 0 (strb all ones) immediately; behaviour after release matches scenario 1.
